jtag_shift_master: RTL and testbench
====================================

# jtag_shift_master

Parametrised, synthesizable JTAG master that turns host scan commands into TCK/TMS/TDI waveforms and returns captured TDO data. It replaces the fixed-delay simulation JTAG driver in front of the SoC debug port and is usable both on the simulation bench and on-chip. It adds a programmable TCK divider, IR/DR scans of variable length, a TAP reset sequence, run-idle padding, and a valid/ready command and response interface.

## Interface
- DATA_W, 32: maximum scan length in bits; width of command and response data.
- LEN_W, 6: width of io_cmd_len; must hold DATA_W.
- DIV_W, 8: width of io_div.

Ports:
- io_clk  in  1  sole clock.
- io_reset  in  1  asynchronous, active-high reset.
- io_cmd_valid  in  1  command offered.
- io_cmd_ready  out  1  command accepted when high together with io_cmd_valid.
- io_cmd_op  in  2  0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = run-idle.
- io_cmd_len  in  LEN_W  bit count for scans; tick count for run-idle.
- io_cmd_data  in  DATA_W  TDI bits, LSB shifted first.
- io_div  in  DIV_W  TCK half-period is io_div+1 io_clk cycles; sampled at accept.
- io_rsp_valid  out  1  scan result available.
- io_rsp_ready  in  1  result consumed.
- io_rsp_data  out  DATA_W  captured TDO, right-aligned.
- io_busy  out  1  high from accept until back in IDLE.
- io_jtag_tck, io_jtag_tms, io_jtag_tdi  out  1  JTAG drive.
- io_jtag_tdo  in  1  JTAG return.

## Operation
- States: IDLE, RST, SEL, SHIFT, EXIT, IDL, RSP.
- One tick = TCK low for io_div+1 cycles, then high for io_div+1 cycles.
- TMS and TDI change only at the start of the low half.
- TDO is registered on the io_clk edge where TCK goes high.
- IDLE: io_cmd_ready = 1. On accept, latch op, len (clamped to DATA_W), data, and div, then branch.
- RST: 6 ticks with TMS = 1,1,1,1,1,0. The TAP ends in Run-Test/Idle. No response.
- SEL: from Run-Test/Idle.
  - IR scan: TMS 1,1,0,0 (4 ticks).
  - DR scan: TMS 1,0,0 (3 ticks).
- SHIFT: len ticks. TDI = data[i]. TMS = 0, except TMS = 1 on the final bit, which moves the TAP to Exit1.
- EXIT: TMS 1,0 (Update, then Run-Test/Idle), then RSP.
- RSP: io_rsp_valid = 1. io_rsp_data[len-1:0] holds the captured bits, bit 0 first captured; upper bits are 0. Held stable until io_rsp_ready, then IDLE.
- IDL: len ticks with TMS = 0. No response.
- Scan with len = 0: no TCK activity. Go directly to RSP with data 0.
- Run-idle with len = 0: return to IDLE next cycle.
- TDI = 0 outside SHIFT. TCK stays low in IDLE and RSP.
- io_cmd_valid while busy is ignored; io_cmd_ready stays 0.

## Timing
- Reset values:
  - io_jtag_tck = 0, io_jtag_tms = 1, io_jtag_tdi = 0.
  - io_cmd_ready = 1, io_rsp_valid = 0, io_rsp_data = 0, io_busy = 0.
- Accept at cycle T. The first low half starts at T+1. The first TCK rise is at T+1+(div+1).
- Durations in ticks:
  - TAP reset: 6 ticks.
  - DR scan: len+5 ticks.
  - IR scan: len+6 ticks.
  - Run-idle: len ticks.
- io_rsp_valid rises on the cycle after the last tick's high half ends.
- io_cmd_ready returns on the cycle after the response handshake, or after the last tick for ops 0 and 3.
- Reset mid-operation:
  - All outputs go to reset values immediately.
  - The pending response is discarded.
  - The TAP state is undefined; the host must issue op 0.
- A change of io_div mid-command has no effect.

## Configuration
- JTAG_MASTER_TRST_EN defined:
  - Adds output io_jtag_trstn (1 bit).
  - io_jtag_trstn = 0 while io_reset is high and throughout all 6 ticks of op 0.
  - io_jtag_trstn = 1 otherwise.
- Not defined: the port is absent and op 0 is a TMS-only reset.

## Test plan
- TAP reset, div = 0: op 0 -> exactly 6 TCK pulses of period 2 cycles; TMS at the rises = 1,1,1,1,1,0; no response.
- DR scan, div = 1, len = 32, data = 0xDEADBEEF, TDO looped to TDI -> 37 ticks, each 4 cycles; io_rsp_data = 0xDEADBEEF; TMS = 1 on shift bit 31 only.
- IR scan, len = 5, data = 0x11, TDO tied 1 -> TMS during SEL = 1,1,0,0; io_rsp_data = 0x1F; total 11 ticks.
- Backpressure: io_rsp_ready held 0 for 20 cycles -> io_rsp_valid and io_rsp_data stable, TCK low, io_cmd_ready 0; a command offered during this window is not accepted.
- Run-idle len = 10, then DR scan len = 0 -> 10 ticks with TMS = 0, then an immediate response of 0 with no TCK.
- io_reset pulsed mid DR shift -> next cycle TCK = 0, TMS = 1, io_rsp_valid = 0, io_cmd_ready = 1; with JTAG_MASTER_TRST_EN, io_jtag_trstn = 0 during the reset pulse.

Source files
------------

// File: rtl/jtag_shift_master.sv
// JTAG scan master: host commands in, TCK/TMS/TDI waveforms out, captured TDO back.
// Optional JTAG_MASTER_TRST_EN adds io_jtag_trstn, driven low during reset and op 0.
module jtag_shift_master #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6,
  parameter int DIV_W  = 8
) (
  input  logic              io_clk,
  input  logic              io_reset,
  input  logic              io_cmd_valid,
  output logic              io_cmd_ready,
  input  logic [1:0]        io_cmd_op,
  input  logic [LEN_W-1:0]  io_cmd_len,
  input  logic [DATA_W-1:0] io_cmd_data,
  input  logic [DIV_W-1:0]  io_div,
  output logic              io_rsp_valid,
  input  logic              io_rsp_ready,
  output logic [DATA_W-1:0] io_rsp_data,
  output logic              io_busy,
  output logic              io_jtag_tck,
  output logic              io_jtag_tms,
  output logic              io_jtag_tdi,
  input  logic              io_jtag_tdo
`ifdef JTAG_MASTER_TRST_EN
  , output logic            io_jtag_trstn
`endif
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SEL, S_SHIFT, S_EXIT, S_IDL, S_RSP
  } state_t;

  state_t            state, nxt_state;
  logic [LEN_W-1:0]  cnt, nxt_cnt;
  logic              op_ir;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] data;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  half_cnt;
  logic              tck, tms, tdi;
  logic [DATA_W-1:0] cap;

  logic              accept, active, nxt_active, half_done, tick_end;
  logic [LEN_W-1:0]  len_c, sel_len;
  logic              sel_ir;
  logic [DATA_W-1:0] sel_data;
  logic [IDX_W-1:0]  idx, nxt_idx;

  // TMS for a given step; the SHIFT exit bit depends on the scan length.
  function automatic logic tms_of(state_t st, logic [LEN_W-1:0] c, logic ir,
                                  logic [LEN_W-1:0] ln);
    case (st)
      S_RST:   tms_of = (c < LEN_W'(5));
      S_SEL:   tms_of = ir ? (c < LEN_W'(2)) : (c == '0);
      S_SHIFT: tms_of = (c == ln - 1'b1);
      S_EXIT:  tms_of = (c == '0);
      default: tms_of = 1'b0;
    endcase
  endfunction

  assign len_c     = (io_cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : io_cmd_len;
  assign accept    = (state == S_IDLE) && io_cmd_valid;
  assign active    = (state != S_IDLE) && (state != S_RSP);
  assign half_done = (half_cnt == div);
  assign tick_end  = active && tck && half_done;
  assign sel_ir    = (state == S_IDLE) ? (io_cmd_op == 2'd1) : op_ir;
  assign sel_len   = (state == S_IDLE) ? len_c : len;
  assign sel_data  = (state == S_IDLE) ? io_cmd_data : data;
  assign idx       = cnt[IDX_W-1:0];
  assign nxt_idx   = nxt_cnt[IDX_W-1:0];
  assign nxt_active = (nxt_state != S_IDLE) && (nxt_state != S_RSP);

  always_ff @(posedge io_clk or posedge io_reset) begin
    if (io_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    case (state)
      S_IDLE: if (io_cmd_valid) begin
        nxt_cnt = '0;
        case (io_cmd_op)
          2'd0:    nxt_state = S_RST;
          2'd3:    nxt_state = (len_c == '0) ? S_IDLE : S_IDL;
          default: nxt_state = (len_c == '0) ? S_RSP : S_SEL;
        endcase
      end
      S_RST: if (tick_end) begin
        if (cnt == LEN_W'(5)) nxt_state = S_IDLE;
        else nxt_cnt = cnt + 1'b1;
      end
      S_SEL: if (tick_end) begin
        if (cnt == (op_ir ? LEN_W'(3) : LEN_W'(2))) begin
          nxt_state = S_SHIFT;
          nxt_cnt   = '0;
        end else nxt_cnt = cnt + 1'b1;
      end
      S_SHIFT: if (tick_end) begin
        if (cnt == len - 1'b1) begin
          nxt_state = S_EXIT;
          nxt_cnt   = '0;
        end else nxt_cnt = cnt + 1'b1;
      end
      S_EXIT: if (tick_end) begin
        if (cnt == LEN_W'(1)) nxt_state = S_RSP;
        else nxt_cnt = cnt + 1'b1;
      end
      S_IDL: if (tick_end) begin
        if (cnt == len - 1'b1) nxt_state = S_IDLE;
        else nxt_cnt = cnt + 1'b1;
      end
      S_RSP: if (io_rsp_ready) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // TMS/TDI are only updated at a tick boundary, i.e. the start of a low half.
  always_ff @(posedge io_clk or posedge io_reset) begin
    if (io_reset) begin
      op_ir    <= 1'b0;
      len      <= '0;
      data     <= '0;
      div      <= '0;
      half_cnt <= '0;
      tck      <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
      cap      <= '0;
    end else begin
      if (accept) begin
        op_ir <= (io_cmd_op == 2'd1);
        len   <= len_c;
        data  <= io_cmd_data;
        div   <= io_div;
        cap   <= '0;
      end
      if (accept || tick_end) begin
        half_cnt <= '0;
        tck      <= 1'b0;
        if (nxt_active) begin
          tms <= tms_of(nxt_state, nxt_cnt, sel_ir, sel_len);
          tdi <= (nxt_state == S_SHIFT) && sel_data[nxt_idx];
        end else begin
          tdi <= 1'b0;
        end
      end else if (active) begin
        if (half_done) begin
          half_cnt <= '0;
          tck      <= 1'b1;
          if (state == S_SHIFT) cap[idx] <= io_jtag_tdo;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end
    end
  end

  assign io_cmd_ready = (state == S_IDLE);
  assign io_busy      = (state != S_IDLE);
  assign io_rsp_valid = (state == S_RSP);
  assign io_rsp_data  = cap;
  assign io_jtag_tck  = tck;
  assign io_jtag_tms  = tms;
  assign io_jtag_tdi  = tdi;

`ifdef JTAG_MASTER_TRST_EN
  assign io_jtag_trstn = !(io_reset || (state == S_RST));
`endif

endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master: table of scan commands plus backpressure and reset sequences.
module tb_jtag_shift_master;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 6;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [DIV_W-1:0]  div = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              tck, tms, tdi, tdo;
  logic [1:0]        tdo_mode = '0;
`ifdef JTAG_MASTER_TRST_EN
  logic              trstn;
`endif

  // tdo_mode: 0 tie low, 1 tie high, 2 loop TDI back
  assign tdo = (tdo_mode == 2'd2) ? tdi : tdo_mode[0];

  always #5 clk = ~clk;

  jtag_shift_master #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
    .io_clk(clk), .io_reset(rst),
    .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready), .io_cmd_op(cmd_op),
    .io_cmd_len(cmd_len), .io_cmd_data(cmd_data), .io_div(div),
    .io_rsp_valid(rsp_valid), .io_rsp_ready(rsp_ready), .io_rsp_data(rsp_data),
    .io_busy(busy), .io_jtag_tck(tck), .io_jtag_tms(tms), .io_jtag_tdi(tdi),
    .io_jtag_tdo(tdo)
`ifdef JTAG_MASTER_TRST_EN
    , .io_jtag_trstn(trstn)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic [7:0]  dv;
    logic [1:0]  mode;
    int          ticks;
    logic [63:0] tms;   // TMS at each TCK rise, bit i = tick i
    logic [63:0] tdi;   // TDI at each TCK rise
    bit          has_rsp;
    logic [31:0] rsp;
  } vec_t;

  vec_t vecs[9];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [1:0] op, input logic [5:0] len, input logic [31:0] d,
                       input logic [7:0] dv, input logic [1:0] mode);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = d; div = dv; tdo_mode = mode;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    logic [63:0] tms_seen = '0;
    logic [63:0] tdi_seen = '0;
    int ticks = 0, end_k = -1, first_rise = -1, last_rise = -1;
    bit bad_period = 0, prev_tck = 0, trst_bad = 0;
    offer(v.op, v.len, v.data, v.dv, v.mode);
    div = 8'd7;  // must be ignored mid-command
    for (int k = 1; k <= 600 && end_k < 0; k++) begin
      if (k > 1) @(negedge clk);
      if (tck && !prev_tck) begin
        if (ticks < 64) begin
          tms_seen[ticks] = tms;
          tdi_seen[ticks] = tdi;
        end
        if (ticks == 0) first_rise = k;
        else if (k - last_rise != 2 * (v.dv + 1)) bad_period = 1;
        last_rise = k;
        ticks++;
`ifdef JTAG_MASTER_TRST_EN
        if (trstn !== (v.op != 2'd0)) trst_bad = 1;
`endif
      end
      prev_tck = tck;
      if (v.has_rsp ? rsp_valid : cmd_ready) end_k = k;
    end
    check($sformatf("v%0d_end_cycle", i), end_k, v.ticks * 2 * (v.dv + 1) + 1);
    check($sformatf("v%0d_ticks", i), ticks, v.ticks);
    check($sformatf("v%0d_tms", i), tms_seen, v.tms);
    check($sformatf("v%0d_tdi", i), tdi_seen, v.tdi);
    check($sformatf("v%0d_trst", i), trst_bad, 0);
    if (v.ticks > 0) begin
      check($sformatf("v%0d_first_rise", i), first_rise, v.dv + 2);
      check($sformatf("v%0d_period", i), bad_period, 0);
    end
    if (v.has_rsp) begin
      check($sformatf("v%0d_rsp_data", i), rsp_data, v.rsp);
      check($sformatf("v%0d_rsp_tck", i), tck, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check($sformatf("v%0d_ready_after", i), {cmd_ready, rsp_valid}, 2'b10);
    end else begin
      check($sformatf("v%0d_no_rsp", i), rsp_valid, 0);
    end
  endtask

  initial begin
    bit ok, bad;
    vecs[0] = '{2'd0, 6'd0,  32'h0,        8'd0, 2'd0, 6,  64'h1F,          64'h0,         1'b0, 32'h0};
    vecs[1] = '{2'd2, 6'd32, 32'hDEADBEEF, 8'd1, 2'd2, 37, 64'hC_0000_0001, 64'h6F56DF778, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{2'd1, 6'd5,  32'h11,       8'd0, 2'd1, 11, 64'h303,         64'h110,       1'b1, 32'h1F};
    vecs[3] = '{2'd3, 6'd10, 32'hFFFFFFFF, 8'd0, 2'd1, 10, 64'h0,           64'h0,         1'b0, 32'h0};
    vecs[4] = '{2'd2, 6'd0,  32'hFF,       8'd0, 2'd1, 0,  64'h0,           64'h0,         1'b1, 32'h0};
    vecs[5] = '{2'd2, 6'd8,  32'hA5,       8'd2, 2'd2, 13, 64'hC01,         64'h528,       1'b1, 32'hA5};
    vecs[6] = '{2'd2, 6'd40, 32'h12345678, 8'd0, 2'd2, 37, 64'hC_0000_0001, 64'h91A2B3C0,  1'b1, 32'h12345678};
    vecs[7] = '{2'd1, 6'd1,  32'hFFFFFFFF, 8'd3, 2'd0, 7,  64'h33,          64'h10,        1'b1, 32'h0};
    vecs[8] = '{2'd3, 6'd0,  32'h0,        8'd0, 2'd0, 0,  64'h0,           64'h0,         1'b0, 32'h0};

    // reset values while held in reset
    @(negedge clk);
    check("reset_outs", {tck, tms, tdi, cmd_ready, rsp_valid, busy}, 6'b010100);
    check("reset_rsp_data", rsp_data, 32'h0);
`ifdef JTAG_MASTER_TRST_EN
    check("reset_trstn", trstn, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i);

    // backpressure: response held, new command offered but refused
    offer(2'd2, 6'd4, 32'h9, 8'd0, 2'd2);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (rsp_valid) ok = 1;
      else @(negedge clk);
    end
    check("bp_rsp_arrives", ok, 1);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 6'd0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 32'h9 || tck || cmd_ready || !busy) bad = 1;
    end
    check("bp_hold_stable", bad, 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release", {cmd_ready, rsp_valid, busy}, 3'b100);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tck || busy) bad = 1;
    end
    check("bp_cmd_not_taken", bad, 0);

    // reset pulsed in the middle of a DR shift
    offer(2'd2, 6'd16, 32'hFFFF, 8'd1, 2'd2);
    repeat (20) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_reset_outs", {tck, tms, tdi, cmd_ready, rsp_valid, busy}, 6'b010100);
    check("mid_reset_rsp_data", rsp_data, 32'h0);
`ifdef JTAG_MASTER_TRST_EN
    check("mid_reset_trstn", trstn, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {cmd_ready, rsp_valid, tck}, 3'b100);
    run_vec(0);
    run_vec(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
